// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - OPW / ALUOPW widths
//   - FSM state encoding (4-bit binary, codes 10..15 unreachable)
//   - opcode class enum produced by ctrl_opclass_decode
//   - opcode constants, ALUOp codes and datapath mux select codes
// ----------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam int OPW    = 6;
    localparam int ALUOPW = 4;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC    = 4'd2,
        ST_ALU_WB  = 4'd3,
        ST_ADDR    = 4'd4,
        ST_MEM_RD  = 4'd5,
        ST_LOAD_WB = 4'd6,
        ST_MEM_WR  = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        CL_ILLEGAL = 4'd0,
        CL_RTYPE   = 4'd1,
        CL_IMM     = 4'd2,
        CL_LOAD    = 4'd3,
        CL_STORE   = 4'd4,
        CL_BEQ     = 4'd5,
        CL_BNE     = 4'd6,
        CL_J       = 4'd7,
        CL_JAL     = 4'd8
    } opclass_t;

    // Opcodes (IR[31:26])
    localparam logic [OPW-1:0] OP_RTYPE = 6'd0;
    localparam logic [OPW-1:0] OP_J     = 6'd2;
    localparam logic [OPW-1:0] OP_JAL   = 6'd3;
    localparam logic [OPW-1:0] OP_BEQ   = 6'd4;
    localparam logic [OPW-1:0] OP_BNE   = 6'd5;
    localparam logic [OPW-1:0] OP_ADDI  = 6'd8;
    localparam logic [OPW-1:0] OP_SLTI  = 6'd10;
    localparam logic [OPW-1:0] OP_SLTIU = 6'd11;
    localparam logic [OPW-1:0] OP_ANDI  = 6'd12;
    localparam logic [OPW-1:0] OP_ORI   = 6'd13;
    localparam logic [OPW-1:0] OP_XORI  = 6'd14;
    localparam logic [OPW-1:0] OP_LUI   = 6'd15;
    localparam logic [OPW-1:0] OP_LW    = 6'd35;
    localparam logic [OPW-1:0] OP_SW    = 6'd43;

    // ALUOp codes
    localparam logic [ALUOPW-1:0] ALUOP_PCADD = 4'd0;
    localparam logic [ALUOPW-1:0] ALUOP_ADDI  = 4'd1;
    localparam logic [ALUOPW-1:0] ALUOP_ANDI  = 4'd2;
    localparam logic [ALUOPW-1:0] ALUOP_ORI   = 4'd3;
    localparam logic [ALUOPW-1:0] ALUOP_XORI  = 4'd4;
    localparam logic [ALUOPW-1:0] ALUOP_BEQ   = 4'd5;
    localparam logic [ALUOPW-1:0] ALUOP_BNE   = 4'd6;
    localparam logic [ALUOPW-1:0] ALUOP_SLTI  = 4'd7;
    localparam logic [ALUOPW-1:0] ALUOP_SLTIU = 4'd8;
    localparam logic [ALUOPW-1:0] ALUOP_LUI   = 4'd9;
    localparam logic [ALUOPW-1:0] ALUOP_LW    = 4'd10;
    localparam logic [ALUOPW-1:0] ALUOP_SW    = 4'd11;
    localparam logic [ALUOPW-1:0] ALUOP_J     = 4'd12;
    localparam logic [ALUOPW-1:0] ALUOP_JAL   = 4'd13;
    localparam logic [ALUOPW-1:0] ALUOP_R     = 4'd15;

    // Datapath mux selects
    localparam logic       IORD_PC      = 1'b0;
    localparam logic       IORD_ALUOUT  = 1'b1;
    localparam logic [1:0] REGDST_RT    = 2'd0;
    localparam logic [1:0] REGDST_RD    = 2'd1;
    localparam logic [1:0] REGDST_RA    = 2'd2;
    localparam logic [1:0] MTR_ALUOUT   = 2'd0;
    localparam logic [1:0] MTR_MDR      = 2'd1;
    localparam logic [1:0] MTR_PC       = 2'd2;
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_A       = 1'b1;
    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMMSH2  = 2'd3;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if
// Control <-> datapath bundle for the multicycle MIPS control unit.
//   master : the control FSM (drives all enables/selects, reads opcode,
//            zero and mem_ready)
//   slave  : the datapath side (drives opcode, zero, mem_ready)
// Signals:
//   opcode[5:0], zero, mem_ready                        datapath -> control
//   pc_write, ir_write, i_or_d, mem_read, mem_write,
//   reg_dst[1:0], mem_to_reg[1:0], reg_write, alu_src_a,
//   alu_src_b[1:0], alu_op[3:0], pc_source[1:0],
//   illegal, state_o[3:0]                               control -> datapath
// ----------------------------------------------------------------------------
interface multicycle_control_if;
    import mips_ctrl_pkg::*;

    logic [OPW-1:0]    opcode;
    logic              zero;
    logic              mem_ready;

    logic              pc_write;
    logic              ir_write;
    logic              i_or_d;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        reg_dst;
    logic [1:0]        mem_to_reg;
    logic              reg_write;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic [ALUOPW-1:0] alu_op;
    logic [1:0]        pc_source;
    logic              illegal;
    logic [3:0]        state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, i_or_d, mem_read, mem_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, i_or_d, mem_read, mem_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, illegal, state_o
    );

endinterface

// File: rtl/multicycle_control_opclass_decode.sv
// ----------------------------------------------------------------------------
// ctrl_opclass_decode
// Pure combinational opcode decoder: maps an opcode to its instruction class
// (which selects the FSM path) and to the ALUOp used in the execute states.
// Ports:
//   i_op     in  OPW     opcode to decode
//   o_class  out 4       opclass_t, CL_ILLEGAL for unknown opcodes
//   o_aluOp  out ALUOPW  ALUOp for this opcode (0 for illegal)
// ----------------------------------------------------------------------------
module ctrl_opclass_decode
    import mips_ctrl_pkg::*;
(
    input  logic [OPW-1:0]    i_op,
    output opclass_t          o_class,
    output logic [ALUOPW-1:0] o_aluOp
);

    always_comb begin
        o_class = CL_ILLEGAL;
        o_aluOp = ALUOP_PCADD;
        case (i_op)
            OP_RTYPE: begin o_class = CL_RTYPE; o_aluOp = ALUOP_R;     end
            OP_ADDI:  begin o_class = CL_IMM;   o_aluOp = ALUOP_ADDI;  end
            OP_ANDI:  begin o_class = CL_IMM;   o_aluOp = ALUOP_ANDI;  end
            OP_ORI:   begin o_class = CL_IMM;   o_aluOp = ALUOP_ORI;   end
            OP_XORI:  begin o_class = CL_IMM;   o_aluOp = ALUOP_XORI;  end
            OP_SLTI:  begin o_class = CL_IMM;   o_aluOp = ALUOP_SLTI;  end
            OP_SLTIU: begin o_class = CL_IMM;   o_aluOp = ALUOP_SLTIU; end
            OP_LUI:   begin o_class = CL_IMM;   o_aluOp = ALUOP_LUI;   end
            OP_LW:    begin o_class = CL_LOAD;  o_aluOp = ALUOP_LW;    end
            OP_SW:    begin o_class = CL_STORE; o_aluOp = ALUOP_SW;    end
            OP_BEQ:   begin o_class = CL_BEQ;   o_aluOp = ALUOP_BEQ;   end
            OP_BNE:   begin o_class = CL_BNE;   o_aluOp = ALUOP_BNE;   end
            OP_J:     begin o_class = CL_J;     o_aluOp = ALUOP_J;     end
            OP_JAL:   begin o_class = CL_JAL;   o_aluOp = ALUOP_JAL;   end
            default:  ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Moore FSM sequencing the multicycle MIPS datapath:
//   FETCH -> DECODE -> class-specific states -> FETCH.
// Outputs are functions of (state, latched opcode); only 'illegal' in DECODE
// and the branch pc_write (from zero) look at live inputs.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    multicycle_control_if.master (opcode/zero/mem_ready in,
//          all datapath enables/selects, illegal and state_o out)
// Build option:
//   MULTICYCLE_CTRL_MEM_WAIT_EN  FETCH, MEM_RD and MEM_WR hold until
//   mem_ready=1; FETCH ir_write/pc_write are gated by mem_ready.
//   Undefined: mem_ready is ignored and memory states last one cycle.
// ----------------------------------------------------------------------------
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    state_t            r_state;
    state_t            w_nextState;
    logic [OPW-1:0]    r_opQ;
    logic              r_run;
    logic [OPW-1:0]    w_decOp;
    opclass_t          w_class;
    logic [ALUOPW-1:0] w_aluOp;
    logic              w_memDone;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    assign w_memDone = bus.mem_ready;
`else
    logic w_unusedMemReady;
    assign w_unusedMemReady = bus.mem_ready;
    assign w_memDone        = 1'b1;
`endif

    // In DECODE the opcode is not yet latched, so the single decoder looks at
    // the live IR field there and at the latched copy everywhere else.
    assign w_decOp = (r_state == ST_DECODE) ? bus.opcode : r_opQ;

    ctrl_opclass_decode u_decode (
        .i_op    (w_decOp),
        .o_class (w_class),
        .o_aluOp (w_aluOp)
    );

    // r_run holds the FSM (and its outputs) quiet until the first edge after
    // reset is released, so FETCH strobes start cleanly on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_opQ   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                r_state <= w_nextState;
                if (r_state == ST_DECODE) begin
                    r_opQ <= bus.opcode;
                end
            end
        end
    end

    always_comb begin
        w_nextState = ST_FETCH;
        case (r_state)
            ST_FETCH:   w_nextState = w_memDone ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (w_class)
                    CL_RTYPE, CL_IMM:  w_nextState = ST_EXEC;
                    CL_LOAD, CL_STORE: w_nextState = ST_ADDR;
                    CL_BEQ, CL_BNE:    w_nextState = ST_BRANCH;
                    CL_J, CL_JAL:      w_nextState = ST_JUMP;
                    default:           w_nextState = ST_FETCH;
                endcase
            end
            ST_EXEC:    w_nextState = ST_ALU_WB;
            ST_ALU_WB:  w_nextState = ST_FETCH;
            ST_ADDR:    w_nextState = (w_class == CL_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  w_nextState = w_memDone ? ST_LOAD_WB : ST_MEM_RD;
            ST_LOAD_WB: w_nextState = ST_FETCH;
            ST_MEM_WR:  w_nextState = w_memDone ? ST_FETCH : ST_MEM_WR;
            ST_BRANCH:  w_nextState = ST_FETCH;
            ST_JUMP:    w_nextState = ST_FETCH;
            default:    w_nextState = ST_FETCH;
        endcase
    end

    // Everything defaults to zero; unreachable state codes and the quiet
    // reset period therefore drive an all-zero control word.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.i_or_d     = IORD_PC;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_dst    = REGDST_RT;
        bus.mem_to_reg = MTR_ALUOUT;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_B;
        bus.alu_op     = ALUOP_PCADD;
        bus.pc_source  = PCSRC_ALU;
        bus.illegal    = 1'b0;
        bus.state_o    = '0;
        if (r_run) begin
            bus.state_o = r_state;
            case (r_state)
                ST_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.ir_write  = w_memDone;
                    bus.pc_write  = w_memDone;
                    bus.alu_src_a = SRCA_PC;
                    bus.alu_src_b = SRCB_FOUR;
                    bus.alu_op    = ALUOP_PCADD;
                    bus.pc_source = PCSRC_ALU;
                end
                ST_DECODE: begin
                    bus.alu_src_a = SRCA_PC;
                    bus.alu_src_b = SRCB_IMMSH2;
                    bus.alu_op    = ALUOP_PCADD;
                    bus.illegal   = (w_class == CL_ILLEGAL);
                end
                ST_EXEC: begin
                    bus.alu_src_a = SRCA_A;
                    bus.alu_src_b = (w_class == CL_RTYPE) ? SRCB_B : SRCB_IMM;
                    bus.alu_op    = w_aluOp;
                end
                ST_ALU_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = (w_class == CL_RTYPE) ? REGDST_RD : REGDST_RT;
                    bus.mem_to_reg = MTR_ALUOUT;
                end
                ST_ADDR: begin
                    bus.alu_src_a = SRCA_A;
                    bus.alu_src_b = SRCB_IMM;
                    bus.alu_op    = w_aluOp;
                end
                ST_MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = IORD_ALUOUT;
                end
                ST_LOAD_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = REGDST_RT;
                    bus.mem_to_reg = MTR_MDR;
                end
                ST_MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = IORD_ALUOUT;
                end
                ST_BRANCH: begin
                    bus.alu_src_a = SRCA_A;
                    bus.alu_src_b = SRCB_B;
                    bus.alu_op    = w_aluOp;
                    bus.pc_source = PCSRC_ALUOUT;
                    bus.pc_write  = (w_class == CL_BEQ) ? bus.zero : ~bus.zero;
                end
                ST_JUMP: begin
                    bus.pc_source = PCSRC_JUMP;
                    bus.pc_write  = 1'b1;
                    bus.alu_op    = w_aluOp;
                    // The PC was already advanced in FETCH, so it is the link value.
                    if (w_class == CL_JAL) begin
                        bus.reg_write  = 1'b1;
                        bus.reg_dst    = REGDST_RA;
                        bus.mem_to_reg = MTR_PC;
                    end
                end
                default: begin
                    bus.state_o = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
// Directed test of multicycle_control. Stimulus pushes hand-computed control
// words into a queue; a monitor pops and compares them on each falling edge.
// Control word layout (24 bits):
//   {state_o, pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst,
//    mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal}
// Honours MULTICYCLE_CTRL_MEM_WAIT_EN for the memory-wait section.
// ----------------------------------------------------------------------------
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [23:0] expQ[$];
    string       tagQ[$];
    int          nChecks = 0;
    int          nFail   = 0;

    logic [23:0] actVec;
    assign actVec = {bus.state_o, bus.pc_write, bus.ir_write, bus.i_or_d,
                     bus.mem_read, bus.mem_write, bus.reg_dst, bus.mem_to_reg,
                     bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.pc_source, bus.illegal};

    function automatic logic [23:0] vec(
        input logic [3:0] st, input logic pcw, input logic irw,
        input logic iord, input logic mr, input logic mw,
        input logic [1:0] rd, input logic [1:0] mtr, input logic rw,
        input logic sa, input logic [1:0] sb, input logic [3:0] aop,
        input logic [1:0] ps, input logic ill);
        return {st, pcw, irw, iord, mr, mw, rd, mtr, rw, sa, sb, aop, ps, ill};
    endfunction

    localparam logic [23:0] V_IDLE = 24'h0;

    function automatic logic [23:0] fetchV();
        return vec(4'd0, 1, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0, 2'd1, 4'd0, 2'd0, 0);
    endfunction

    function automatic logic [23:0] decodeV(input logic ill);
        return vec(4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd3, 4'd0, 2'd0, ill);
    endfunction

    task automatic checkOutput(input logic [23:0] act, input logic [23:0] exp,
                               input string tag);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic z,
                                 input logic rdy, input logic [23:0] e,
                                 input string tag);
        @(posedge clk);
        #1;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expQ.push_back(V_IDLE);
        tagQ.push_back("idle after release");
    endtask

    // Monitor: every falling edge, compare against the oldest expectation.
    initial begin
        logic [23:0] e;
        string       t;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                t = tagQ.pop_front();
                checkOutput(actVec, e, t);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;

        applyStimulus(6'd0, 0, 1, V_IDLE, "reset held 1");
        applyStimulus(6'd0, 0, 1, V_IDLE, "reset held 2");
        releaseReset();

        // R-type: 4 cycles
        applyStimulus(6'd0, 0, 1, fetchV(), "R fetch");
        applyStimulus(6'd0, 0, 1, decodeV(0), "R decode");
        applyStimulus(6'd0, 0, 1, vec(4'd2, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd0, 4'd15, 2'd0, 0), "R exec");
        applyStimulus(6'd0, 0, 1, vec(4'd3, 0,0,0,0,0, 2'd1,2'd0, 1, 0, 2'd0, 4'd0, 2'd0, 0), "R alu_wb");

        // addi
        applyStimulus(6'd8, 0, 1, fetchV(), "addi fetch");
        applyStimulus(6'd8, 0, 1, decodeV(0), "addi decode");
        applyStimulus(6'd8, 0, 1, vec(4'd2, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd2, 4'd1, 2'd0, 0), "addi exec");
        applyStimulus(6'd8, 0, 1, vec(4'd3, 0,0,0,0,0, 2'd0,2'd0, 1, 0, 2'd0, 4'd0, 2'd0, 0), "addi alu_wb");

        // lui (exec only differs in alu_op)
        applyStimulus(6'd15, 0, 1, fetchV(), "lui fetch");
        applyStimulus(6'd15, 0, 1, decodeV(0), "lui decode");
        applyStimulus(6'd15, 0, 1, vec(4'd2, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd2, 4'd9, 2'd0, 0), "lui exec");
        applyStimulus(6'd15, 0, 1, vec(4'd3, 0,0,0,0,0, 2'd0,2'd0, 1, 0, 2'd0, 4'd0, 2'd0, 0), "lui alu_wb");

        // lw: 5 cycles
        applyStimulus(6'd35, 0, 1, fetchV(), "lw fetch");
        applyStimulus(6'd35, 0, 1, decodeV(0), "lw decode");
        applyStimulus(6'd35, 0, 1, vec(4'd4, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd2, 4'd10, 2'd0, 0), "lw addr");
        applyStimulus(6'd35, 0, 1, vec(4'd5, 0,0,1,1,0, 2'd0,2'd0, 0, 0, 2'd0, 4'd0, 2'd0, 0), "lw mem_rd");
        applyStimulus(6'd35, 0, 1, vec(4'd6, 0,0,0,0,0, 2'd0,2'd1, 1, 0, 2'd0, 4'd0, 2'd0, 0), "lw load_wb");

        // sw: 4 cycles
        applyStimulus(6'd43, 0, 1, fetchV(), "sw fetch");
        applyStimulus(6'd43, 0, 1, decodeV(0), "sw decode");
        applyStimulus(6'd43, 0, 1, vec(4'd4, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd2, 4'd11, 2'd0, 0), "sw addr");
        applyStimulus(6'd43, 0, 1, vec(4'd7, 0,0,1,0,1, 2'd0,2'd0, 0, 0, 2'd0, 4'd0, 2'd0, 0), "sw mem_wr");

        // Branches: taken/not-taken for beq and bne
        applyStimulus(6'd4, 1, 1, fetchV(), "beq z1 fetch");
        applyStimulus(6'd4, 1, 1, decodeV(0), "beq z1 decode");
        applyStimulus(6'd4, 1, 1, vec(4'd8, 1,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd0, 4'd5, 2'd1, 0), "beq z1 branch");
        applyStimulus(6'd4, 0, 1, fetchV(), "beq z0 fetch");
        applyStimulus(6'd4, 0, 1, decodeV(0), "beq z0 decode");
        applyStimulus(6'd4, 0, 1, vec(4'd8, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd0, 4'd5, 2'd1, 0), "beq z0 branch");
        applyStimulus(6'd5, 1, 1, fetchV(), "bne z1 fetch");
        applyStimulus(6'd5, 1, 1, decodeV(0), "bne z1 decode");
        applyStimulus(6'd5, 1, 1, vec(4'd8, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd0, 4'd6, 2'd1, 0), "bne z1 branch");
        applyStimulus(6'd5, 0, 1, fetchV(), "bne z0 fetch");
        applyStimulus(6'd5, 0, 1, decodeV(0), "bne z0 decode");
        applyStimulus(6'd5, 0, 1, vec(4'd8, 1,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd0, 4'd6, 2'd1, 0), "bne z0 branch");

        // jal and j: 3 cycles
        applyStimulus(6'd3, 0, 1, fetchV(), "jal fetch");
        applyStimulus(6'd3, 0, 1, decodeV(0), "jal decode");
        applyStimulus(6'd3, 0, 1, vec(4'd9, 1,0,0,0,0, 2'd2,2'd2, 1, 0, 2'd0, 4'd13, 2'd2, 0), "jal jump");
        applyStimulus(6'd2, 0, 1, fetchV(), "j fetch");
        applyStimulus(6'd2, 0, 1, decodeV(0), "j decode");
        applyStimulus(6'd2, 0, 1, vec(4'd9, 1,0,0,0,0, 2'd0,2'd0, 0, 0, 2'd0, 4'd12, 2'd2, 0), "j jump");

        // Illegal opcodes: 2 cycles, pulse in DECODE, straight back to FETCH
        applyStimulus(6'd63, 0, 1, fetchV(), "ill63 fetch");
        applyStimulus(6'd63, 0, 1, decodeV(1), "ill63 decode");
        applyStimulus(6'd1, 0, 1, fetchV(), "ill1 fetch");
        applyStimulus(6'd1, 0, 1, decodeV(1), "ill1 decode");
        applyStimulus(6'd0, 0, 1, fetchV(), "fetch after illegal");

        // Reset asserted in the middle of MEM_WR
        applyStimulus(6'd0, 0, 1, decodeV(0), "R decode before sw");
        applyStimulus(6'd0, 0, 1, vec(4'd2, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd0, 4'd15, 2'd0, 0), "R exec before sw");
        applyStimulus(6'd0, 0, 1, vec(4'd3, 0,0,0,0,0, 2'd1,2'd0, 1, 0, 2'd0, 4'd0, 2'd0, 0), "R alu_wb before sw");
        applyStimulus(6'd43, 0, 1, fetchV(), "sw2 fetch");
        applyStimulus(6'd43, 0, 1, decodeV(0), "sw2 decode");
        applyStimulus(6'd43, 0, 1, vec(4'd4, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd2, 4'd11, 2'd0, 0), "sw2 addr");
        applyStimulus(6'd43, 0, 1, vec(4'd7, 0,0,1,0,1, 2'd0,2'd0, 0, 0, 2'd0, 4'd0, 2'd0, 0), "sw2 mem_wr");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput(actVec, V_IDLE, "async reset drops mem_wr");
        applyStimulus(6'd43, 0, 1, V_IDLE, "reset held mid sw");
        releaseReset();
        applyStimulus(6'd0, 0, 1, fetchV(), "fetch after mid reset");
        applyStimulus(6'd0, 0, 1, decodeV(0), "decode after mid reset");
        applyStimulus(6'd0, 0, 1, vec(4'd2, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd0, 4'd15, 2'd0, 0), "R exec after mid reset");
        applyStimulus(6'd0, 0, 1, vec(4'd3, 0,0,0,0,0, 2'd1,2'd0, 1, 0, 2'd0, 4'd0, 2'd0, 0), "R alu_wb after mid reset");

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        // FETCH and MEM_WR stall on mem_ready; strobes stay steady.
        applyStimulus(6'd43, 0, 0, vec(4'd0, 0,0,0,1,0, 2'd0,2'd0, 0, 0, 2'd1, 4'd0, 2'd0, 0), "wait fetch stall");
        applyStimulus(6'd43, 0, 1, fetchV(), "wait fetch go");
        applyStimulus(6'd43, 0, 1, decodeV(0), "wait sw decode");
        applyStimulus(6'd43, 0, 1, vec(4'd4, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd2, 4'd11, 2'd0, 0), "wait sw addr");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'd43, 0, 0, vec(4'd7, 0,0,1,0,1, 2'd0,2'd0, 0, 0, 2'd0, 4'd0, 2'd0, 0), "wait sw mem_wr held");
        end
        applyStimulus(6'd43, 0, 1, vec(4'd7, 0,0,1,0,1, 2'd0,2'd0, 0, 0, 2'd0, 4'd0, 2'd0, 0), "wait sw mem_wr done");
        applyStimulus(6'd35, 0, 1, fetchV(), "wait lw fetch");
        applyStimulus(6'd35, 0, 1, decodeV(0), "wait lw decode");
        applyStimulus(6'd35, 0, 1, vec(4'd4, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd2, 4'd10, 2'd0, 0), "wait lw addr");
        applyStimulus(6'd35, 0, 0, vec(4'd5, 0,0,1,1,0, 2'd0,2'd0, 0, 0, 2'd0, 4'd0, 2'd0, 0), "wait lw mem_rd held");
        applyStimulus(6'd35, 0, 1, vec(4'd5, 0,0,1,1,0, 2'd0,2'd0, 0, 0, 2'd0, 4'd0, 2'd0, 0), "wait lw mem_rd done");
        applyStimulus(6'd35, 0, 1, vec(4'd6, 0,0,0,0,0, 2'd0,2'd1, 1, 0, 2'd0, 4'd0, 2'd0, 0), "wait lw load_wb");
        applyStimulus(6'd0, 0, 1, fetchV(), "wait final fetch");
`else
        // mem_ready low is ignored: every memory state lasts one cycle.
        applyStimulus(6'd43, 0, 0, fetchV(), "nowait sw fetch");
        applyStimulus(6'd43, 0, 0, decodeV(0), "nowait sw decode");
        applyStimulus(6'd43, 0, 0, vec(4'd4, 0,0,0,0,0, 2'd0,2'd0, 0, 1, 2'd2, 4'd11, 2'd0, 0), "nowait sw addr");
        applyStimulus(6'd43, 0, 0, vec(4'd7, 0,0,1,0,1, 2'd0,2'd0, 0, 0, 2'd0, 4'd0, 2'd0, 0), "nowait sw mem_wr");
        applyStimulus(6'd0, 0, 0, fetchV(), "nowait final fetch");
`endif

        repeat (3) @(posedge clk);
        nChecks++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("[TB] FAIL queue drain: got %0d pending expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
